// File: rtl/prbs_scrambler_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : prbs_scrambler_param
// Purpose  : PRBS-7/15/23/31 word scrambler with LSB-first serialiser and
//            per-frame reseeding over a valid/ready input.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module prbs_scrambler_param #(
  parameter int          DATA_W  = 8,
  parameter int          FRAME_W = 3,
  parameter logic [30:0] SEED    = 31'h7FFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_random,
  output logic               par_valid,
  output logic               data_out,
  output logic               ser_valid,
  output logic               ser_sof
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [0:0]        ST_IDLE  = 1'b0;
  localparam logic [0:0]        ST_SHIFT = 1'b1;

  function automatic logic [30:0] len_mask(input logic [1:0] m);
    case (m)
      2'd0:    len_mask = 31'h0000_007F;
      2'd1:    len_mask = 31'h0000_7FFF;
      2'd2:    len_mask = 31'h007F_FFFF;
      default: len_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic fb_of(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    fb_of = s[6]  ^ s[5];
      2'd1:    fb_of = s[14] ^ s[13];
      2'd2:    fb_of = s[22] ^ s[17];
      default: fb_of = s[30] ^ s[27];
    endcase
  endfunction

  logic [30:0]        lfsr_q, lfsr_d;
  logic [1:0]         act_mode_q, act_mode_d;
  logic [FRAME_W-1:0] word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]  data_random_q, data_random_d;
  logic               par_valid_q, par_valid_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [0:0]         state_q, state_d;
  logic               sof_q, sof_d;

  logic               w_accept;
  logic               w_frame_start;
  logic               w_wrap;
  logic [1:0]         w_eff_mode;
  logic [30:0]        w_step;
  logic               w_fb;
  logic [DATA_W-1:0]  w_mask;
  logic [DATA_W-1:0]  w_scrambled;

  assign in_ready    = rst & ((state_q == ST_IDLE) | (bit_cnt_q == LAST_BIT));
  assign w_accept    = in_valid & in_ready;
  assign data_random = data_random_q;
  assign par_valid   = par_valid_q;
  assign data_out    = sreg_q[0];
  assign ser_valid   = (state_q == ST_SHIFT);
  assign ser_sof     = sof_q;

  assign w_frame_start = (word_cnt_q == '0);
  assign w_eff_mode    = w_frame_start ? mode : act_mode_q;
  assign w_wrap        = (frame_len != '0) && (word_cnt_q >= (frame_len - FRAME_W'(1)));

  // Mask generation; a mode switch at frame start restarts the new polynomial from SEED.
  always_comb begin
    w_mask = '0;
    w_fb   = 1'b0;
    if (w_frame_start && (mode != act_mode_q)) begin
      w_step = SEED & len_mask(mode);
    end else begin
      w_step = lfsr_q;
    end
    for (int i = 0; i < DATA_W; i++) begin
      w_fb      = fb_of(w_step, w_eff_mode);
      w_mask[i] = w_fb;
      w_step    = {w_step[29:0], w_fb} & len_mask(w_eff_mode);
    end
  end

  assign w_scrambled = data_in ^ w_mask;

  always_comb begin
    lfsr_d        = lfsr_q;
    act_mode_d    = act_mode_q;
    word_cnt_d    = word_cnt_q;
    data_random_d = data_random_q;
    par_valid_d   = 1'b0;
    sreg_d        = sreg_q;
    bit_cnt_d     = bit_cnt_q;
    state_d       = state_q;
    sof_d         = 1'b0;
    if (w_accept) begin
      act_mode_d    = w_eff_mode;
      data_random_d = w_scrambled;
      par_valid_d   = 1'b1;
      lfsr_d        = w_wrap ? (SEED & len_mask(w_eff_mode)) : w_step;
      word_cnt_d    = ((frame_len == '0) || w_wrap) ? '0 : word_cnt_q + FRAME_W'(1);
      sreg_d        = w_scrambled;
      bit_cnt_d     = '0;
      sof_d         = w_frame_start;
      state_d       = ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      if (bit_cnt_q == LAST_BIT) begin
        state_d   = ST_IDLE;
        sreg_d    = '0;
        bit_cnt_d = '0;
      end else begin
        sreg_d    = sreg_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q        <= SEED & len_mask(mode);
      act_mode_q    <= mode;
      word_cnt_q    <= '0;
      data_random_q <= '0;
      par_valid_q   <= 1'b0;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      state_q       <= ST_IDLE;
      sof_q         <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      act_mode_q    <= act_mode_d;
      word_cnt_q    <= word_cnt_d;
      data_random_q <= data_random_d;
      par_valid_q   <= par_valid_d;
      sreg_q        <= sreg_d;
      bit_cnt_q     <= bit_cnt_d;
      state_q       <= state_d;
      sof_q         <= sof_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs_scrambler_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_prbs_scrambler_param
// Purpose  : Vector table, corner sequences and randomized traffic against a
//            bit-recurrence PRBS model for prbs_scrambler_param.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_prbs_scrambler_param;

  localparam int          DW   = 8;
  localparam int          FW   = 3;
  localparam logic [30:0] SEED = 31'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [FW-1:0] frame_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_random;
  logic          par_valid;
  logic          data_out;
  logic          ser_valid;
  logic          ser_sof;

  prbs_scrambler_param #(.DATA_W(DW), .FRAME_W(FW), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .mode(mode), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .data_random(data_random), .par_valid(par_valid),
    .data_out(data_out), .ser_valid(ser_valid), .ser_sof(ser_sof)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: generated bit g[n] = g[n-L] ^ g[n-T], history preloaded from SEED.
  logic [30:0] seed_v = SEED;
  bit          hist[$];
  int          m_act;
  int          m_wc;

  function automatic int len_of(input int m);
    case (m)
      0: return 7;
      1: return 15;
      2: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int tap_of(input int m);
    case (m)
      0: return 6;
      1: return 14;
      2: return 18;
      default: return 28;
    endcase
  endfunction

  task automatic m_seed(input int m);
    hist.delete();
    for (int k = len_of(m) - 1; k >= 0; k--) hist.push_back(seed_v[k]);
  endtask

  task automatic m_accept(input logic [7:0] d, input int md, input int fl,
                          output logic [7:0] e, output logic sof);
    logic [7:0] msk;
    bit b;
    sof = (m_wc == 0);
    if (m_wc == 0 && md != m_act) begin
      m_act = md;
      m_seed(md);
    end
    for (int i = 0; i < 8; i++) begin
      b = hist[hist.size() - len_of(m_act)] ^ hist[hist.size() - tap_of(m_act)];
      hist.push_back(b);
      if (hist.size() > 64) void'(hist.pop_front());
      msk[i] = b;
    end
    e = d ^ msk;
    if (fl == 0) m_wc = 0;
    else if (m_wc >= fl - 1) begin
      m_wc = 0;
      m_seed(m_act);
    end else m_wc++;
  endtask

  typedef struct packed { logic b; logic s; } sb_t;
  sb_t serq[$];

  // Scoreboard: captures the pre-edge handshake, checks the post-edge outputs.
  always begin : monitor
    logic          rst_s, acc_s, sf;
    logic [1:0]    md_s;
    logic [FW-1:0] fl_s;
    logic [7:0]    d_s, e;
    sb_t           x;
    @(negedge clk);
    rst_s = rst;
    acc_s = rst && in_valid && in_ready;
    md_s  = mode;
    fl_s  = frame_len;
    d_s   = data_in;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      m_act = int'(md_s);
      m_wc  = 0;
      m_seed(m_act);
      serq.delete();
      chk("rst_par_valid", par_valid, 0);
      chk("rst_data_random", data_random, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_ser_sof", ser_sof, 0);
    end else begin
      if (acc_s) begin
        m_accept(d_s, int'(md_s), int'(fl_s), e, sf);
        chk("par_valid", par_valid, 1);
        chk("data_random", data_random, e);
        for (int i = 0; i < 8; i++) serq.push_back({e[i], (i == 0) && sf});
      end else begin
        chk("par_idle", par_valid, 0);
      end
      if (serq.size() > 0) begin
        x = serq.pop_front();
        chk("ser_valid", ser_valid, 1);
        chk("data_out", data_out, x.b);
        chk("ser_sof", ser_sof, x.s);
      end else begin
        chk("ser_idle", ser_valid, 0);
        chk("sof_idle", ser_sof, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, output logic [7:0] r);
    logic ok;
    int   n;
    in_valid = 1'b1;
    data_in  = d;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    r = data_random;
  endtask

  typedef struct {
    logic          rst_first;
    logic [1:0]    md;
    logic [FW-1:0] fl;
    logic [7:0]    din;
    logic [7:0]    exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0] r, bits, sofs;
    logic       acc;
    int         naccs;

    tbl.push_back('{1'b1, 2'd0, 3'd0, 8'h00, 8'h40});
    tbl.push_back('{1'b1, 2'd0, 3'd0, 8'hCC, 8'h8C});
    tbl.push_back('{1'b1, 2'd1, 3'd2, 8'hCC, 8'hCC});
    tbl.push_back('{1'b0, 2'd1, 3'd2, 8'hDD, 8'h9D});
    tbl.push_back('{1'b0, 2'd1, 3'd2, 8'hEE, 8'hEE});
    tbl.push_back('{1'b0, 2'd1, 3'd2, 8'hFF, 8'hBF});
    tbl.push_back('{1'b1, 2'd1, 3'd4, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 2'd1, 3'd4, 8'h00, 8'h40});
    tbl.push_back('{1'b0, 2'd0, 3'd4, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 2'd0, 3'd4, 8'h00, 8'h30});
    tbl.push_back('{1'b0, 2'd0, 3'd4, 8'h00, 8'h40});

    // Reset held with valid asserted: the word must be dropped.
    rst      = 1'b0;
    in_valid = 1'b1;
    data_in  = 8'hAA;
    repeat (3) step();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    step();

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      mode      = tbl[i].md;
      frame_len = tbl[i].fl;
      send(tbl[i].din, r);
      chk($sformatf("vec%0d", i), r, tbl[i].exp);
    end
    repeat (10) step();

    // Serial order and start-of-frame marker for one PRBS-7 word.
    do_reset();
    mode = 2'd0;
    frame_len = '0;
    send(8'hCC, r);
    for (int i = 0; i < 8; i++) begin
      bits[i] = data_out;
      sofs[i] = ser_sof;
      step();
    end
    chk("ser_bits", bits, 8'h8C);
    chk("ser_sof_pos", sofs, 8'h01);
    repeat (4) step();

    // Held valid: one accept per word time, ready only on the last bit.
    in_valid = 1'b1;
    data_in  = 8'h5A;
    naccs    = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      acc = in_ready;
      chk($sformatf("bp_ready%0d", i), acc, (i % 8) == 0);
      if (acc) naccs++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepts", naccs, 3);
    repeat (10) step();

    // Reset in the middle of a serial word.
    do_reset();
    mode = 2'd0;
    send(8'h00, r);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("abort_ser_valid", ser_valid, 0);
    rst = 1'b1;
    send(8'h00, r);
    chk("after_abort", r, 8'h40);
    repeat (10) step();

    // Randomized traffic across all modes and frame lengths.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (!in_valid || acc || !rst) begin
        in_valid = ($urandom_range(9) < 7);
        data_in  = 8'($urandom);
      end
      if ($urandom_range(39) == 0) mode = 2'($urandom);
      if ($urandom_range(79) == 0) frame_len = FW'($urandom);
      rst = ($urandom_range(249) != 0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
